// File: rtl/mem_port_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port, 1-cycle-latency on-chip RAM.
// Round-robin grant, registered read-return tag, contention statistics and read/write error flag.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_W-1:0]     s0_address,
    input  logic [DATA_W/8-1:0]   s0_byteenable,
    input  logic                  s0_read,
    input  logic                  s0_write,
    input  logic [DATA_W-1:0]     s0_writedata,
    output logic                  s0_waitrequest,
    output logic [DATA_W-1:0]     s0_readdata,
    output logic                  s0_readdatavalid,

    input  logic [ADDR_W-1:0]     s1_address,
    input  logic [DATA_W/8-1:0]   s1_byteenable,
    input  logic                  s1_read,
    input  logic                  s1_write,
    input  logic [DATA_W-1:0]     s1_writedata,
    output logic                  s1_waitrequest,
    output logic [DATA_W-1:0]     s1_readdata,
    output logic                  s1_readdatavalid,

    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata,

    output logic [CNT_W-1:0]      contention_cnt,
    output logic                  err_rw
);

    localparam int unsigned BE_W = DATA_W / 8;

    typedef struct packed {
        logic valid;
        logic id;
    } ret_tag_t;

    logic     req0;
    logic     req1;
    logic     gnt0;
    logic     gnt1;
    logic     both_req;
    logic     rd_accept;
    logic     last_grant;
    ret_tag_t tag_q;

    // Round-robin grant; last_grant = 1 means port 1 was served last, so port 0 wins a tie.
    always_comb begin
        req0     = s0_read | s0_write;
        req1     = s1_read | s1_write;
        both_req = req0 & req1 & ~reset;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        if (!reset) begin
            if (req0 && req1) begin
                gnt0 = last_grant;
                gnt1 = ~last_grant;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_comb begin
        s0_waitrequest = req0 & ~gnt0 & ~reset;
        s1_waitrequest = req1 & ~gnt1 & ~reset;
    end

    // RAM pin mux; everything reads as zero when nobody is granted.
    always_comb begin
        mem_address    = '0;
        mem_byteenable = BE_W'(0);
        mem_writedata  = '0;
        mem_write      = 1'b0;
        if (gnt0) begin
            mem_address    = s0_address;
            mem_byteenable = s0_byteenable;
            mem_writedata  = s0_writedata;
            mem_write      = s0_write;
        end else if (gnt1) begin
            mem_address    = s1_address;
            mem_byteenable = s1_byteenable;
            mem_writedata  = s1_writedata;
            mem_write      = s1_write;
        end
        mem_chipselect = gnt0 | gnt1;
        mem_clken      = ~reset;
    end

    // A read that arrives together with a write is dropped, so it never creates a return tag.
    always_comb begin
        rd_accept = (gnt0 & s0_read & ~s0_write) | (gnt1 & s1_read & ~s1_write);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant     <= 1'b1;
            tag_q          <= '0;
            contention_cnt <= '0;
            err_rw         <= 1'b0;
        end else begin
            if (gnt0) begin
                last_grant <= 1'b0;
            end else if (gnt1) begin
                last_grant <= 1'b1;
            end
            tag_q.valid <= rd_accept;
            tag_q.id    <= gnt1;
            if (both_req && (contention_cnt != {CNT_W{1'b1}})) begin
                contention_cnt <= contention_cnt + CNT_W'(1);
            end
            if ((s0_read && s0_write) || (s1_read && s1_write)) begin
                err_rw <= 1'b1;
            end
        end
    end

    always_comb begin
        s0_readdatavalid = tag_q.valid & ~tag_q.id & ~reset;
        s1_readdatavalid = tag_q.valid & tag_q.id & ~reset;
        s0_readdata      = mem_readdata;
        s1_readdata      = mem_readdata;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 8192x32 byte-enabled RAM behind it.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] s0_address, s1_address;
    logic [3:0]  s0_byteenable, s1_byteenable;
    logic        s0_read, s1_read, s0_write, s1_write;
    logic [31:0] s0_writedata, s1_writedata;
    logic        s0_waitrequest, s1_waitrequest;
    logic [31:0] s0_readdata, s1_readdata;
    logic        s0_readdatavalid, s1_readdatavalid;
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic [15:0] contention_cnt;
    logic        err_rw;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] ram [0:8191];

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .s0_address       (s0_address),
        .s0_byteenable    (s0_byteenable),
        .s0_read          (s0_read),
        .s0_write         (s0_write),
        .s0_writedata     (s0_writedata),
        .s0_waitrequest   (s0_waitrequest),
        .s0_readdata      (s0_readdata),
        .s0_readdatavalid (s0_readdatavalid),
        .s1_address       (s1_address),
        .s1_byteenable    (s1_byteenable),
        .s1_read          (s1_read),
        .s1_write         (s1_write),
        .s1_writedata     (s1_writedata),
        .s1_waitrequest   (s1_waitrequest),
        .s1_readdata      (s1_readdata),
        .s1_readdatavalid (s1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata),
        .contention_cnt   (contention_cnt),
        .err_rw           (err_rw)
    );

    // Single-port RAM: write at the edge, registered q one cycle after the read edge.
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
                end
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        s0_read = 1'b0; s0_write = 1'b0; s0_address = '0; s0_byteenable = '0; s0_writedata = '0;
        s1_read = 1'b0; s1_write = 1'b0; s1_address = '0; s1_byteenable = '0; s1_writedata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic wr(input int port, input logic [12:0] a, input logic [31:0] d, input logic [3:0] be);
        idle();
        if (port == 0) begin
            s0_write = 1'b1; s0_address = a; s0_writedata = d; s0_byteenable = be;
        end else begin
            s1_write = 1'b1; s1_address = a; s1_writedata = d; s1_byteenable = be;
        end
        step();
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        s0_read = 1'b1;
        s1_read = 1'b1;
        #12;
        chk("rst_s0_wait", 32'(s0_waitrequest), 32'h0);
        chk("rst_s1_wait", 32'(s1_waitrequest), 32'h0);
        chk("rst_cs", 32'(mem_chipselect), 32'h0);
        chk("rst_clken", 32'(mem_clken), 32'h0);
        chk("rst_cnt", 32'(contention_cnt), 32'h0);
        chk("rst_err", 32'(err_rw), 32'h0);
        @(negedge clk);
        idle();
        reset = 1'b0;
        #1;
        chk("clken_up", 32'(mem_clken), 32'h1);

        // single-port write then read on port 0
        s0_write = 1'b1; s0_address = 13'h0010; s0_writedata = 32'hDEADBEEF; s0_byteenable = 4'hF;
        #1;
        chk("p0_wr_wait", 32'(s0_waitrequest), 32'h0);
        chk("p0_wr_memwr", 32'(mem_write), 32'h1);
        chk("p0_wr_addr", 32'(mem_address), 32'h10);
        step();
        idle();
        s0_read = 1'b1; s0_address = 13'h0010;
        #1;
        chk("p0_rd_wait", 32'(s0_waitrequest), 32'h0);
        chk("p0_rd_memwr", 32'(mem_write), 32'h0);
        step();
        idle();
        #1;
        chk("p0_rdv", 32'(s0_readdatavalid), 32'h1);
        chk("p0_rdata", s0_readdata, 32'hDEADBEEF);
        chk("p0_rdv_s1", 32'(s1_readdatavalid), 32'h0);
        step();
        chk("p0_rdv_once", 32'(s0_readdatavalid), 32'h0);

        // byte-lane write on port 1 at the top address
        wr(1, 13'h1FFF, 32'hAABBCCDD, 4'hF);
        wr(1, 13'h1FFF, 32'h11223344, 4'h5);
        // byteenable zero is still forwarded and changes nothing
        s0_write = 1'b1; s0_address = 13'h1FFF; s0_writedata = 32'hFFFFFFFF; s0_byteenable = 4'h0;
        #1;
        chk("be0_wait", 32'(s0_waitrequest), 32'h0);
        chk("be0_cs", 32'(mem_chipselect), 32'h1);
        chk("be0_be", 32'(mem_byteenable), 32'h0);
        chk("be0_data", mem_writedata, 32'hFFFFFFFF);
        step();
        idle();
        s1_read = 1'b1; s1_address = 13'h1FFF;
        step();
        idle();
        #1;
        chk("p1_rdv", 32'(s1_readdatavalid), 32'h1);
        chk("p1_rdata", s1_readdata, 32'hAA22CC44);
        chk("p1_rdv_s0", 32'(s0_readdatavalid), 32'h0);

        // contention: preload, reset so port 0 wins first, then 6 cycles of dual reads
        wr(0, 13'h0100, 32'h01000100, 4'hF);
        wr(1, 13'h0200, 32'h02000200, 4'hF);
        pulse_reset();
        #1;
        chk("cont_cnt0", 32'(contention_cnt), 32'h0);
        s0_read = 1'b1; s0_address = 13'h0100;
        s1_read = 1'b1; s1_address = 13'h0200;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("cont_w0_%0d", k), 32'(s0_waitrequest), 32'(k % 2));
            chk($sformatf("cont_w1_%0d", k), 32'(s1_waitrequest), 32'((k + 1) % 2));
            chk($sformatf("cont_addr_%0d", k), 32'(mem_address), (k % 2 == 0) ? 32'h100 : 32'h200);
            if (k > 0) begin
                chk($sformatf("cont_v0_%0d", k), 32'(s0_readdatavalid), 32'(k % 2));
                chk($sformatf("cont_v1_%0d", k), 32'(s1_readdatavalid), 32'((k + 1) % 2));
                chk($sformatf("cont_d_%0d", k), mem_readdata, (k % 2 == 1) ? 32'h01000100 : 32'h02000200);
            end
            step();
        end
        idle();
        #1;
        chk("cont_last_v1", 32'(s1_readdatavalid), 32'h1);
        chk("cont_last_d1", s1_readdata, 32'h02000200);
        chk("cont_last_v0", 32'(s0_readdatavalid), 32'h0);
        chk("cont_cnt6", 32'(contention_cnt), 32'h6);

        // read+write collision on port 0
        s0_read = 1'b1; s0_write = 1'b1; s0_address = 13'h0005; s0_writedata = 32'h77; s0_byteenable = 4'hF;
        #1;
        chk("rw_memwr", 32'(mem_write), 32'h1);
        step();
        idle();
        #1;
        chk("rw_no_rdv0", 32'(s0_readdatavalid), 32'h0);
        chk("rw_no_rdv1", 32'(s1_readdatavalid), 32'h0);
        chk("rw_err", 32'(err_rw), 32'h1);
        s0_read = 1'b1; s0_address = 13'h0005;
        step();
        idle();
        #1;
        chk("rw_rb_v", 32'(s0_readdatavalid), 32'h1);
        chk("rw_rb_d", s0_readdata, 32'h77);
        step();
        chk("rw_err_sticky", 32'(err_rw), 32'h1);

        // reset while a port-1 read return is in flight
        s1_read = 1'b1; s1_address = 13'h0200;
        @(posedge clk);
        #1;
        idle();
        chk("mid_rdv_pre", 32'(s1_readdatavalid), 32'h1);
        reset = 1'b1;
        #1;
        chk("mid_rdv", 32'(s1_readdatavalid), 32'h0);
        chk("mid_clken", 32'(mem_clken), 32'h0);
        chk("mid_cnt", 32'(contention_cnt), 32'h0);
        chk("mid_err", 32'(err_rw), 32'h0);
        @(negedge clk);
        step();
        reset = 1'b0;
        s1_read = 1'b1; s1_address = 13'h0200;
        #1;
        chk("mid_post_wait", 32'(s1_waitrequest), 32'h0);
        step();
        idle();
        #1;
        chk("mid_post_v", 32'(s1_readdatavalid), 32'h1);
        chk("mid_post_d", s1_readdata, 32'h02000200);

        // saturation over 2^16 + 10 contended cycles
        pulse_reset();
        s0_read = 1'b1; s0_address = 13'h0100;
        s1_read = 1'b1; s1_address = 13'h0200;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        chk("sat_fffe", 32'(contention_cnt), 32'hFFFE);
        step();
        chk("sat_ffff", 32'(contention_cnt), 32'hFFFF);
        repeat (11) @(posedge clk);
        @(negedge clk);
        chk("sat_hold", 32'(contention_cnt), 32'hFFFF);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master Avalon-MM arbiter placed directly upstream of a single-port on-chip RAM (8192 x 32, byte-enabled, 1-cycle read latency). It lets two Nios cores share one memory tile. Access uses round-robin fairness, and each accepted read is returned with a qualifying readdatavalid pulse. It drives the RAM's address, byteenable, chipselect, write, writedata and clken pins, and consumes its readdata.

## Interface
- ADDR_W, 13: word-address width; must match RAM widthad
- DATA_W, 32: data width; byteenable width is DATA_W/8
- CNT_W, 16: width of the saturating contention counter
- clk  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high reset
- s0_address / s1_address  in  ADDR_W  word address from core 0 / core 1
- s0_byteenable / s1_byteenable  in  DATA_W/8  byte lanes
- s0_read / s1_read  in  1  read request
- s0_write / s1_write  in  1  write request
- s0_writedata / s1_writedata  in  DATA_W  write data
- s0_waitrequest / s1_waitrequest  out  1  request not accepted this cycle
- s0_readdata / s1_readdata  out  DATA_W  read data, valid only while readdatavalid is high
- s0_readdatavalid / s1_readdatavalid  out  1  one-cycle read return strobe
- mem_address  out  ADDR_W  to RAM
- mem_byteenable  out  DATA_W/8  to RAM
- mem_chipselect, mem_write  out  1  to RAM
- mem_writedata  out  DATA_W  to RAM
- mem_clken  out  1  RAM clock enable
- mem_readdata  in  DATA_W  from RAM (unregistered q)
- contention_cnt  out  CNT_W  number of cycles in which both ports requested; saturating
- err_rw  out  1  sticky flag: a port asserted read and write in the same cycle

## Operation
- **Request:** a port is requesting when read or write is high.
- **Grant:**
  - Combinational, at most one port per cycle.
  - If only one port requests, that port is granted.
  - If both request, the port other than last_grant is granted.
  - last_grant updates on every granted cycle.
- **Waitrequest:** sN_waitrequest = requesting and not granted. A stalled master holds its request stable.
- **Acceptance:** a request is accepted on the rising edge where it is requesting and its waitrequest is low.
- **RAM drive:**
  - mem_address, byteenable and writedata are muxed from the granted port.
  - mem_chipselect = any grant.
  - mem_write = the granted port's write.
  - mux outputs are zero when there is no grant.
- **mem_clken:** 1 whenever reset is low; 0 while reset is high.
- **Read return:**
  - A registered return tag (valid bit plus port id) is set on an accepted read.
  - sN_readdatavalid = tag.valid and tag.id == N.
  - Both sN_readdata outputs are driven from mem_readdata.
- **Read and write in one cycle:**
  - The write is performed; the read is dropped and no readdatavalid is produced.
  - err_rw sets and stays set until reset.
- **Contention counter:** contention_cnt increments on every cycle in which both ports request, and saturates at all-ones.
- **Byteenable zero:** a write with byteenable = 0 is still granted and forwarded to the RAM unchanged.
- **Reset (asynchronous):**
  - last_grant = 1, so port 0 wins the first contention.
  - Return tag cleared; any in-flight readdatavalid is suppressed.
  - contention_cnt = 0, err_rw = 0.
  - Outputs during reset: all waitrequest, readdatavalid, mem_chipselect, mem_write, mem_clken = 0.

## Timing
- Accepts one access per cycle with no bubbles. Back-to-back reads from alternating ports sustain 100% RAM utilisation.
- Write latency: the RAM is written at the accepting edge.
- Read latency: exactly 1 cycle. readdatavalid is high in the cycle after acceptance, for one cycle per accepted read.
- Under continuous contention the grant alternates every cycle, so each port waits at most 1 cycle.
- waitrequest and the mem_* pins are combinational from the requests and last_grant. There is no registered path from input to output other than the return tag.
- Reset deassertion is synchronised externally; the first request is honoured on the first edge after reset falls.

## Test plan
- **Single-port write/read:** port 0 writes 0xDEADBEEF to address 0x0010 with byteenable 0xF, then reads 0x0010. Required:
  - s0_waitrequest stays 0 throughout.
  - s0_readdatavalid is high exactly 1 cycle after the read is accepted, with s0_readdata = 0xDEADBEEF.
  - s1_readdatavalid stays 0.
- **Byte-lane write:** port 1 writes 0x11223344 to 0x1FFF with byteenable 0x5 over a location holding 0xAABBCCDD, then reads it back. Required: read returns 0xAA22CC44 on s1.
- **Contention:** both ports issue reads for 6 cycles, to addresses 0x0100 and 0x0200 preloaded with distinct values. Required:
  - Grants go 0,1,0,1,... starting with port 0 after reset.
  - Each port sees waitrequest high on alternate cycles.
  - Each return is tagged to the correct port with the correct data.
  - contention_cnt = 6.
- **Read+write collision:** port 0 asserts read and write together to 0x0005 with writedata 0x00000077. Required:
  - Memory holds 0x77.
  - No readdatavalid is produced.
  - err_rw = 1 and stays 1 until reset.
- **Reset mid-operation:** assert reset in the cycle after a port-1 read is accepted. Required:
  - s1_readdatavalid = 0 immediately.
  - mem_clken = 0 and contention_cnt = 0.
  - After release, port 1's next read is accepted and returns correct data.
- **Saturation:** hold both ports requesting for 2^CNT_W + 10 cycles. Required: contention_cnt = 0xFFFF and does not wrap.
